// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if: serial input stream, control and output handshake signals for serial_deserializer.
interface serial_deserializer_if #(parameter int BUS_WIDTH = 32);
    logic                 i_shift;
    logic                 i_valid;
    logic                 i_sht_lr;
    logic                 i_flush;
    logic                 i_ready;
    logic [BUS_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 o_busy;
    logic                 o_overrun;
    modport master (
        output i_shift, i_valid, i_sht_lr, i_flush, i_ready,
        input  o_data, o_valid, o_busy, o_overrun
    );
    modport slave (
        input  i_shift, i_valid, i_sht_lr, i_flush, i_ready,
        output o_data, o_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// serial_deserializer: rebuilds BUS_WIDTH-bit words from a serial bit stream into a one-entry valid/ready slot.
// Define DESER_TIMEOUT_EN to drop a partial word after TIMEOUT_CYCLES consecutive idle cycles.
module serial_deserializer #(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  rst,
    serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(BUS_WIDTH) + 1;
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BUS_WIDTH-1:0] sr, sr_nx, data;
    logic                 ord, ord_nx, cur_ord, flush, done, valid, overrun;
`ifdef DESER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap;
    logic          tmo;
    assign tmo   = state == COLLECT && !bus.i_valid && gap == GW'(TIMEOUT_CYCLES - 1);
    assign flush = bus.i_flush | tmo;
    always_ff @(posedge clk)
        if (rst || bus.i_valid || flush || state == IDLE) gap <= '0;
        else gap <= gap + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign flush          = bus.i_flush;
`endif
    // The order bit is sampled only on the first bit; later i_sht_lr changes are ignored.
    assign cur_ord = state == IDLE ? bus.i_sht_lr : ord;
    assign done    = state == COLLECT && bus.i_valid && !flush && cnt == CW'(BUS_WIDTH - 1);
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sr_nx    = sr;
        ord_nx   = ord;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (bus.i_valid) begin
            sr_nx    = cur_ord ? {bus.i_shift, sr[BUS_WIDTH-1:1]} : {sr[BUS_WIDTH-2:0], bus.i_shift};
            ord_nx   = cur_ord;
            state_nx = done ? IDLE : COLLECT;
            cnt_nx   = done ? '0 : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            ord     <= 1'b0;
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sr    <= sr_nx;
            ord   <= ord_nx;
            if (done && (!valid || bus.i_ready)) begin
                data  <= sr_nx;
                valid <= 1'b1;
            end else begin
                if (bus.i_ready) valid <= 1'b0;
                if (done) overrun <= 1'b1;
            end
        end
    assign bus.o_data    = data;
    assign bus.o_valid   = valid;
    assign bus.o_busy    = state == COLLECT;
    assign bus.o_overrun = overrun;
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed stimulus with a word scoreboard popped by a handshake monitor.
module tb_serial_deserializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    serial_deserializer_if #(.BUS_WIDTH(32)) bus ();
    serial_deserializer #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send_bits(input logic [31:0] w, input int n, input logic lsb, input int gap,
                             input int tog, input logic chk_busy);
        bus.i_sht_lr = lsb;
        for (int i = 0; i < n; i++) begin
            bus.i_valid = 1'b1;
            bus.i_shift = lsb ? w[i] : w[31-i];
            if (i == tog) bus.i_sht_lr = ~bus.i_sht_lr;
            tick();
            if (chk_busy) chk("busy_during_word", {31'b0, bus.o_busy}, {31'b0, i < 31});
            bus.i_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask
    always @(negedge clk)
        if (!rst && bus.o_valid && bus.i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h expected none", bus.o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.o_data !== mon_exp) begin
                    errors++;
                    $display("FAIL word_data: got %h expected %h", bus.o_data, mon_exp);
                end
            end
        end
    initial begin
        bus.i_valid  = 1'b1;
        bus.i_shift  = 1'b1;
        bus.i_sht_lr = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_data", bus.o_data, 32'h0);
            chk("rst_flags", {28'b0, bus.o_valid, bus.o_busy, bus.o_overrun, 1'b0}, 32'h0);
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        send_bits(32'hDEADBEEF, 32, 1'b0, 0, -1, 1'b0);
        chk("msb_valid_rise", {31'b0, bus.o_valid}, 32'h1);
        tick();
        chk("msb_valid_drop", {31'b0, bus.o_valid}, 32'h0);
        exp_q.push_back(32'h8000_0001);
        send_bits(32'h8000_0001, 32, 1'b1, 1, 10, 1'b1);
        tick();
        bus.i_ready = 1'b0;
        exp_q.push_back(32'h1111_1111);
        send_bits(32'h1111_1111, 32, 1'b0, 0, -1, 1'b0);
        chk("ovr_first_clear", {31'b0, bus.o_overrun}, 32'h0);
        send_bits(32'h2222_2222, 32, 1'b0, 0, -1, 1'b0);
        chk("ovr_set", {31'b0, bus.o_overrun}, 32'h1);
        chk("ovr_data_held", bus.o_data, 32'h1111_1111);
        chk("ovr_valid_held", {31'b0, bus.o_valid}, 32'h1);
        bus.i_ready = 1'b1;
        tick();
        chk("ovr_drain", {31'b0, bus.o_valid}, 32'h0);
        send_bits(32'hFFFF_FFFF, 10, 1'b0, 0, -1, 1'b0);
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_shift = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_busy", {31'b0, bus.o_busy}, 32'h0);
        exp_q.push_back(32'hA5A5_A5A5);
        send_bits(32'hA5A5_A5A5, 32, 1'b0, 0, -1, 1'b0);
        tick();
        send_bits(32'h1234_5678, 31, 1'b0, 0, -1, 1'b0);
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_shift = 1'b0;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_last_valid", {31'b0, bus.o_valid}, 32'h0);
        chk("flush_last_busy", {31'b0, bus.o_busy}, 32'h0);
        send_bits(32'hFFFF_0000, 16, 1'b1, 0, -1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, bus.o_busy}, 32'h0);
        chk("midrst_overrun", {31'b0, bus.o_overrun}, 32'h0);
        exp_q.push_back(32'h0F0F_F0F0);
        send_bits(32'h0F0F_F0F0, 32, 1'b0, 0, -1, 1'b0);
        tick();
`ifdef DESER_TIMEOUT_EN
        send_bits(32'hFFFF_FFFF, 5, 1'b0, 0, -1, 1'b0);
        repeat (9) tick();
        chk("tmo_busy", {31'b0, bus.o_busy}, 32'h0);
        exp_q.push_back(32'h3C3C_5AA5);
        send_bits(32'h3C3C_5AA5, 32, 1'b0, 0, -1, 1'b0);
        tick();
        chk("tmo_overrun", {31'b0, bus.o_overrun}, 32'h0);
`endif
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
